// File: rtl/affine_cu_scheduler_if.sv
// CU request / affine core handshake bundle for the affine CU scheduler.
// The scheduler takes the slave view; the CU source and core model take the master view.
interface affine_cu_scheduler_if;
    logic        CU_START;
    logic [7:0]  CU_COORD_X;
    logic [7:0]  CU_COORD_Y;
    logic [7:0]  CU_WIDTH;
    logic [7:0]  CU_HEIGHT;
    logic [15:0] CPMV_0_IN;
    logic [15:0] CPMV_1_IN;
    logic        CORE_DONE;
    logic        CORE_START;
    logic [7:0]  CORE_COORD_X;
    logic [7:0]  CORE_COORD_Y;
    logic [15:0] CORE_CPMV_0;
    logic [15:0] CORE_CPMV_1;
    logic [9:0]  SUBBLOCK_IDX;
    logic        BUSY;
    logic        CU_DONE;
    logic        ERR_FLAG;

    modport slave (
        input  CU_START, CU_COORD_X, CU_COORD_Y, CU_WIDTH, CU_HEIGHT,
        input  CPMV_0_IN, CPMV_1_IN, CORE_DONE,
        output CORE_START, CORE_COORD_X, CORE_COORD_Y,
        output CORE_CPMV_0, CORE_CPMV_1, SUBBLOCK_IDX,
        output BUSY, CU_DONE, ERR_FLAG
    );

    modport master (
        output CU_START, CU_COORD_X, CU_COORD_Y, CU_WIDTH, CU_HEIGHT,
        output CPMV_0_IN, CPMV_1_IN, CORE_DONE,
        input  CORE_START, CORE_COORD_X, CORE_COORD_Y,
        input  CORE_CPMV_0, CORE_CPMV_1, SUBBLOCK_IDX,
        input  BUSY, CU_DONE, ERR_FLAG
    );
endinterface

// File: rtl/affine_cu_scheduler.sv
// Walks a CU in 4x4 raster order, issuing one affine core job per sub-block
// with a per-sub-block WAIT timeout and a sticky error flag.
module affine_cu_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESET_ALL,
    affine_cu_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [7:0]  w_q, w_d;
    logic [7:0]  h_q, h_d;
    logic [15:0] cpmv0_q, cpmv0_d;
    logic [15:0] cpmv1_q, cpmv1_d;
    logic [7:0]  xoff_q, xoff_d;
    logic [7:0]  yoff_q, yoff_d;
    logic [9:0]  idx_q, idx_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;

    logic        legal;
    logic        row_end;
    logic        last_sb;

    function automatic logic size_ok(input logic [7:0] s);
        return (s != 8'd0) && (s[1:0] == 2'b00) && (s <= 8'd128);
    endfunction

    assign legal   = size_ok(bus.CU_WIDTH) && size_ok(bus.CU_HEIGHT);
    assign row_end = (xoff_q + 8'd4) == w_q;
    assign last_sb = row_end && ((yoff_q + 8'd4) == h_q);

    always_ff @(posedge CLK or posedge RESET_ALL) begin
        if (RESET_ALL) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cpmv0_q <= '0;
            cpmv1_q <= '0;
            xoff_q  <= '0;
            yoff_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cpmv0_q <= cpmv0_d;
            cpmv1_q <= cpmv1_d;
            xoff_q  <= xoff_d;
            yoff_q  <= yoff_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        cpmv0_d = cpmv0_q;
        cpmv1_d = cpmv1_q;
        xoff_d  = xoff_q;
        yoff_d  = yoff_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.CU_START) begin
                    if (legal) begin
                        x_d     = bus.CU_COORD_X;
                        y_d     = bus.CU_COORD_Y;
                        w_d     = bus.CU_WIDTH;
                        h_d     = bus.CU_HEIGHT;
                        cpmv0_d = bus.CPMV_0_IN;
                        cpmv1_d = bus.CPMV_1_IN;
                        xoff_d  = '0;
                        yoff_d  = '0;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the threshold cycle still counts as success.
                if (bus.CORE_DONE) begin
                    if (last_sb) begin
                        state_d = S_DONE;
                    end else begin
                        if (row_end) begin
                            xoff_d = '0;
                            yoff_d = yoff_q + 8'd4;
                        end else begin
                            xoff_d = xoff_q + 8'd4;
                        end
                        idx_d   = idx_q + 10'd1;
                        state_d = S_ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.CORE_START   = (state_q == S_ISSUE);
    assign bus.CU_DONE      = (state_q == S_DONE);
    assign bus.BUSY         = (state_q != S_IDLE);
    assign bus.CORE_COORD_X = x_q + xoff_q;
    assign bus.CORE_COORD_Y = y_q + yoff_q;
    assign bus.CORE_CPMV_0  = cpmv0_q;
    assign bus.CORE_CPMV_1  = cpmv1_q;
    assign bus.SUBBLOCK_IDX = idx_q;
    assign bus.ERR_FLAG     = err_q;
endmodule

// File: tb/tb_affine_cu_scheduler.sv
// Directed table-driven bench for affine_cu_scheduler with a latency-programmable
// core model, plus hand sequences for timeout, async reset and ignored inputs.
module tb_affine_cu_scheduler;
    logic CLK = 1'b0;
    logic RESET_ALL;

    affine_cu_scheduler_if bus();

    affine_cu_scheduler #(.TIMEOUT_CYCLES(255)) dut (
        .CLK       (CLK),
        .RESET_ALL (RESET_ALL),
        .bus       (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    logic [7:0] cx [0:7];
    logic [7:0] cy [0:7];
    logic [9:0] ci [0:7];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] w;
        logic [7:0] h;
        int         lat;
        logic       ferr;
        int         starts;
        int         dones;
        logic [7:0] lx;
        logic [7:0] ly;
        logic [9:0] lidx;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_cu(
        input  logic [7:0] x, input logic [7:0] y,
        input  logic [7:0] w, input logic [7:0] h,
        input  int lat,
        output int starts, output int dones,
        output logic [7:0] lx, output logic [7:0] ly, output logic [9:0] lidx,
        output int gap, output logic busy_ok, output logic cpmv_ok,
        output logic in_budget
    );
        int cnt;
        int cyc;
        int last_core;
        logic pending;
        cnt = 0; cyc = 0; last_core = -100; pending = 1'b0;
        starts = 0; dones = 0; lx = '0; ly = '0; lidx = '0;
        gap = -1; busy_ok = 1'b1; cpmv_ok = 1'b1; in_budget = 1'b0;
        @(negedge CLK);
        bus.CU_COORD_X = x;
        bus.CU_COORD_Y = y;
        bus.CU_WIDTH   = w;
        bus.CU_HEIGHT  = h;
        bus.CPMV_0_IN  = {x, y};
        bus.CPMV_1_IN  = {h, w};
        bus.CU_START   = 1'b1;
        @(negedge CLK);
        bus.CU_START = 1'b0;
        while (cyc < 20000) begin
            bus.CORE_DONE = 1'b0;
            if (bus.CORE_START) begin
                if (starts < 8) begin
                    cx[starts] = bus.CORE_COORD_X;
                    cy[starts] = bus.CORE_COORD_Y;
                    ci[starts] = bus.SUBBLOCK_IDX;
                end
                if (bus.CORE_CPMV_0 !== {x, y} || bus.CORE_CPMV_1 !== {h, w})
                    cpmv_ok = 1'b0;
                starts++;
                lx = bus.CORE_COORD_X;
                ly = bus.CORE_COORD_Y;
                lidx = bus.SUBBLOCK_IDX;
                cnt = lat;
                pending = 1'b1;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    bus.CORE_DONE = 1'b1;
                    pending = 1'b0;
                    last_core = cyc;
                end
            end
            if (bus.CU_DONE) begin
                dones++;
                gap = cyc - last_core;
                if (!bus.BUSY) busy_ok = 1'b0;
            end
            if (!bus.BUSY) begin
                in_budget = 1'b1;
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        bus.CORE_DONE = 1'b0;
    endtask

    task automatic wait_start(output logic ok);
        int n;
        n = 0;
        while (!bus.CORE_START && n < 50) begin
            @(negedge CLK);
            n++;
        end
        ok = bus.CORE_START;
    endtask

    initial begin
        int starts, dones, gap;
        logic [7:0] lx, ly;
        logic [9:0] lidx;
        logic busy_ok, cpmv_ok, in_budget, ok;
        int n;

        tbl[0]  = '{8'd16,  8'd32,  8'd8,   8'd8,   5,   1'b0, 4,    1, 8'd20,  8'd36,  10'd3};
        tbl[1]  = '{8'd0,   8'd0,   8'd6,   8'd4,   1,   1'b1, 0,    0, 8'd0,   8'd0,   10'd0};
        tbl[2]  = '{8'd0,   8'd0,   8'd4,   8'd4,   2,   1'b0, 1,    1, 8'd0,   8'd0,   10'd0};
        tbl[3]  = '{8'd252, 8'd10,  8'd8,   8'd4,   3,   1'b0, 2,    1, 8'd0,   8'd10,  10'd1};
        tbl[4]  = '{8'd0,   8'd0,   8'd0,   8'd4,   1,   1'b1, 0,    0, 8'd0,   8'd0,   10'd0};
        tbl[5]  = '{8'd0,   8'd0,   8'd4,   8'd132, 1,   1'b1, 0,    0, 8'd0,   8'd0,   10'd0};
        tbl[6]  = '{8'd100, 8'd200, 8'd16,  8'd8,   1,   1'b0, 8,    1, 8'd112, 8'd204, 10'd7};
        tbl[7]  = '{8'd250, 8'd254, 8'd12,  8'd8,   2,   1'b0, 6,    1, 8'd2,   8'd2,   10'd5};
        tbl[8]  = '{8'd8,   8'd8,   8'd4,   8'd4,   256, 1'b1, 1,    0, 8'd8,   8'd8,   10'd0};
        tbl[9]  = '{8'd8,   8'd8,   8'd4,   8'd4,   255, 1'b0, 1,    1, 8'd8,   8'd8,   10'd0};
        tbl[10] = '{8'd0,   8'd0,   8'd8,   8'd130, 1,   1'b1, 0,    0, 8'd0,   8'd0,   10'd0};
        tbl[11] = '{8'd0,   8'd0,   8'd128, 8'd128, 1,   1'b0, 1024, 1, 8'd124, 8'd124, 10'd1023};

        RESET_ALL = 1'b1;
        bus.CU_START = 1'b0; bus.CORE_DONE = 1'b0;
        bus.CU_COORD_X = '0; bus.CU_COORD_Y = '0;
        bus.CU_WIDTH = '0; bus.CU_HEIGHT = '0;
        bus.CPMV_0_IN = '0; bus.CPMV_1_IN = '0;
        #1;
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_start", bus.CORE_START, 0);
        chk("rst_cudone", bus.CU_DONE, 0);
        chk("rst_err", bus.ERR_FLAG, 0);
        chk("rst_idx", bus.SUBBLOCK_IDX, 0);
        @(negedge CLK);
        RESET_ALL = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_cu(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].lat,
                   starts, dones, lx, ly, lidx, gap, busy_ok, cpmv_ok, in_budget);
            chk($sformatf("v%0d_budget", i), in_budget, 1);
            chk($sformatf("v%0d_err", i), bus.ERR_FLAG, tbl[i].ferr);
            chk($sformatf("v%0d_starts", i), starts, tbl[i].starts);
            chk($sformatf("v%0d_dones", i), dones, tbl[i].dones);
            chk($sformatf("v%0d_busy_end", i), bus.BUSY, 0);
            if (tbl[i].starts > 0) begin
                chk($sformatf("v%0d_last_x", i), lx, tbl[i].lx);
                chk($sformatf("v%0d_last_y", i), ly, tbl[i].ly);
                chk($sformatf("v%0d_last_idx", i), lidx, tbl[i].lidx);
                chk($sformatf("v%0d_cpmv", i), cpmv_ok, 1);
            end
            if (tbl[i].dones > 0) begin
                chk($sformatf("v%0d_done_gap", i), gap, 1);
                chk($sformatf("v%0d_done_busy", i), busy_ok, 1);
            end
            if (i == 0) begin
                chk("nom_x0", cx[0], 16); chk("nom_y0", cy[0], 32);
                chk("nom_x1", cx[1], 20); chk("nom_y1", cy[1], 32);
                chk("nom_x2", cx[2], 16); chk("nom_y2", cy[2], 36);
                chk("nom_x3", cx[3], 20); chk("nom_y3", cy[3], 36);
                for (int k = 0; k < 4; k++)
                    chk($sformatf("nom_idx%0d", k), ci[k], k);
            end
            if (i == 3) begin
                chk("wrap_x0", cx[0], 252);
                chk("wrap_x1", cx[1], 0);
            end
        end

        // Timeout with the core never answering: cycle-exact ERR entry.
        @(negedge CLK);
        bus.CU_WIDTH = 8'd4; bus.CU_HEIGHT = 8'd4;
        bus.CU_COORD_X = 8'd0; bus.CU_COORD_Y = 8'd0;
        bus.CU_START = 1'b1;
        @(negedge CLK);
        bus.CU_START = 1'b0;
        chk("tmo_issue", bus.CORE_START, 1);
        n = 0;
        while (!bus.ERR_FLAG && n < 400) begin
            chk("tmo_no_cudone", bus.CU_DONE, 0);
            @(negedge CLK);
            n++;
        end
        chk("tmo_cycles", n, 256);
        chk("tmo_busy_in_err", bus.BUSY, 1);
        chk("tmo_cudone_in_err", bus.CU_DONE, 0);
        @(negedge CLK);
        chk("tmo_idle_next", bus.BUSY, 0);
        chk("tmo_err_sticky", bus.ERR_FLAG, 1);

        // Async reset mid-WAIT of sub-block 2 of a 16x16 CU.
        @(negedge CLK);
        bus.CU_WIDTH = 8'd16; bus.CU_HEIGHT = 8'd16;
        bus.CU_COORD_X = 8'd40; bus.CU_COORD_Y = 8'd60;
        bus.CPMV_0_IN = 16'hABCD; bus.CPMV_1_IN = 16'h1234;
        bus.CU_START = 1'b1;
        @(negedge CLK);
        bus.CU_START = 1'b0;
        chk("rst_seq_err_cleared", bus.ERR_FLAG, 0);
        for (int sb = 0; sb < 2; sb++) begin
            wait_start(ok);
            chk($sformatf("rst_seq_start%0d", sb), ok, 1);
            @(negedge CLK); bus.CORE_DONE = 1'b1;
            @(negedge CLK); bus.CORE_DONE = 1'b0;
        end
        wait_start(ok);
        chk("rst_seq_start2", ok, 1);
        chk("rst_seq_idx2", bus.SUBBLOCK_IDX, 2);
        chk("rst_seq_x2", bus.CORE_COORD_X, 48);
        @(negedge CLK);
        @(negedge CLK);
        #2 RESET_ALL = 1'b1;
        #1;
        chk("arst_busy", bus.BUSY, 0);
        chk("arst_start", bus.CORE_START, 0);
        chk("arst_cudone", bus.CU_DONE, 0);
        chk("arst_err", bus.ERR_FLAG, 0);
        chk("arst_idx", bus.SUBBLOCK_IDX, 0);
        chk("arst_x", bus.CORE_COORD_X, 0);
        chk("arst_y", bus.CORE_COORD_Y, 0);
        chk("arst_cpmv0", bus.CORE_CPMV_0, 0);
        chk("arst_cpmv1", bus.CORE_CPMV_1, 0);
        @(negedge CLK);
        RESET_ALL = 1'b0;
        bus.CU_WIDTH = 8'd4; bus.CU_HEIGHT = 8'd4;
        bus.CU_COORD_X = 8'd4; bus.CU_COORD_Y = 8'd4;
        bus.CU_START = 1'b1;
        @(negedge CLK);
        bus.CU_START = 1'b0;
        chk("post_rst_start", bus.CORE_START, 1);
        chk("post_rst_idx", bus.SUBBLOCK_IDX, 0);
        chk("post_rst_x", bus.CORE_COORD_X, 4);
        @(negedge CLK); bus.CORE_DONE = 1'b1;
        @(negedge CLK); bus.CORE_DONE = 1'b0;
        chk("post_rst_cudone", bus.CU_DONE, 1);
        @(negedge CLK);
        chk("post_rst_idle", bus.BUSY, 0);

        // CORE_DONE in IDLE is ignored.
        @(negedge CLK); bus.CORE_DONE = 1'b1;
        @(negedge CLK); bus.CORE_DONE = 1'b0;
        chk("idle_done_busy", bus.BUSY, 0);
        chk("idle_done_start", bus.CORE_START, 0);
        chk("idle_done_cudone", bus.CU_DONE, 0);
        @(negedge CLK);
        chk("idle_done_busy2", bus.BUSY, 0);

        // CU_START during WAIT is ignored, even with an illegal size.
        bus.CU_WIDTH = 8'd8; bus.CU_HEIGHT = 8'd4;
        bus.CU_COORD_X = 8'd0; bus.CU_COORD_Y = 8'd0;
        bus.CU_START = 1'b1;
        @(negedge CLK);
        bus.CU_START = 1'b0;
        chk("wait_start_issue", bus.CORE_START, 1);
        @(negedge CLK);
        bus.CU_START = 1'b1; bus.CU_WIDTH = 8'd6; bus.CU_COORD_X = 8'd99;
        @(negedge CLK);
        bus.CU_START = 1'b0; bus.CORE_DONE = 1'b1;
        @(negedge CLK);
        bus.CORE_DONE = 1'b0;
        chk("wait_start_next", bus.CORE_START, 1);
        chk("wait_start_x", bus.CORE_COORD_X, 4);
        chk("wait_start_idx", bus.SUBBLOCK_IDX, 1);
        chk("wait_start_err", bus.ERR_FLAG, 0);
        @(negedge CLK); bus.CORE_DONE = 1'b1;
        @(negedge CLK); bus.CORE_DONE = 1'b0;
        chk("wait_start_cudone", bus.CU_DONE, 1);
        @(negedge CLK);
        chk("wait_start_idle", bus.BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/affine_cu_scheduler.md
AFFINE_CU_SCHEDULER -- requirements
Module: affine_cu_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of WAIT cycles allowed per sub-block (1..255).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET_ALL, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port CU_START, input, 1 bit: request to process one CU; sampled only in IDLE.
REQ-005 SHALL have ports CU_COORD_X and CU_COORD_Y, input, 8 bits each: CU top-left sample position.
REQ-006 SHALL have ports CU_WIDTH and CU_HEIGHT, input, 8 bits each: CU size in samples; legal values are multiples of 4 in the range 4..128.
REQ-007 SHALL have ports CPMV_0_IN and CPMV_1_IN, input, 16 bits each: control-point MVs for the CU.
REQ-008 SHALL have port CORE_DONE, input, 1 bit: completion pulse from the affine MV-gen/interpolation core.
REQ-009 SHALL have port CORE_START, output, 1 bit: one-cycle start pulse to the core.
REQ-010 SHALL have ports CORE_COORD_X and CORE_COORD_Y, output, 8 bits each: current 4x4 sub-block position.
REQ-011 SHALL have ports CORE_CPMV_0 and CORE_CPMV_1, output, 16 bits each: latched CPMVs.
REQ-012 SHALL have port SUBBLOCK_IDX, output, 10 bits: raster index of the current sub-block.
REQ-013 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port CU_DONE, output, 1 bit: one-cycle pulse when the CU completes.
REQ-015 SHALL have port ERR_FLAG, output, 1 bit: sticky error flag.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT, DONE and ERR.
REQ-017 SHALL, in IDLE with CU_START=1 and legal sizes: latch coordinates, sizes and CPMVs; clear the offsets, SUBBLOCK_IDX and ERR_FLAG; and go to ISSUE on the next edge.
REQ-018 SHALL, in IDLE with CU_START=1 and an illegal size (zero, nonzero bits [1:0], or greater than 128): set ERR_FLAG, stay in IDLE, and produce no CORE_START.
REQ-019 SHALL, in ISSUE, drive CORE_START=1 for exactly one cycle and go to WAIT.
REQ-020 SHALL drive CORE_COORD_X = (latched X + x_off) mod 256 and CORE_COORD_Y = (latched Y + y_off) mod 256, held stable from ISSUE through the end of WAIT.
REQ-021 SHALL clear the timeout counter on entry to WAIT and increment it on each WAIT cycle with CORE_DONE=0.
REQ-022 SHALL, in WAIT with CORE_DONE=1 and not the last sub-block, advance to the next sub-block and go to ISSUE:
- advance order is raster: x_off += 4; when x_off+4 = width, x_off = 0 and y_off += 4;
- SUBBLOCK_IDX += 1.
REQ-023 SHALL, in WAIT with CORE_DONE=1 on the last sub-block (x_off+4 = width and y_off+4 = height), go to DONE.
REQ-024 SHALL, in DONE, assert CU_DONE for one cycle and go to IDLE.
REQ-025 SHALL, in WAIT with CORE_DONE=0 after TIMEOUT_CYCLES consecutive WAIT cycles, go to ERR.
REQ-026 SHALL, in ERR, set ERR_FLAG, suppress CU_DONE, and go to IDLE on the next edge.
REQ-027 SHALL let CORE_DONE win when CORE_DONE=1 and the timeout threshold occur in the same cycle.
REQ-028 SHALL ignore CORE_DONE outside WAIT and CU_START outside IDLE.
REQ-029 SHALL achieve a per-sub-block overhead of exactly 1 cycle (ISSUE) plus the WAIT duration; CU_DONE SHALL rise one cycle after the final CORE_DONE.
REQ-030 SHALL hold ERR_FLAG until RESET_ALL or the next legal CU_START is accepted.
REQ-031 SHALL handle the maximum CU of 128x128 as 1024 sub-blocks, with SUBBLOCK_IDX ending at 1023 without overflow.

Reset
REQ-032 SHALL, on RESET_ALL=1, immediately and asynchronously, including mid-operation:
- force state to IDLE;
- force every output and internal register to 0.
REQ-033 SHALL accept CU_START on the first edge after RESET_ALL deasserts.

Verification
REQ-034 SHALL be verified by a nominal CU: 8x8 at (16,32), core returns CORE_DONE 5 cycles after each start.
- Expect 4 CORE_START pulses with coords (16,32), (20,32), (16,36), (20,36) and SUBBLOCK_IDX 0..3.
- Expect one CU_DONE pulse one cycle after the 4th CORE_DONE, then BUSY=0.
REQ-035 SHALL be verified by CU_WIDTH=6 with CU_START: expect ERR_FLAG=1, BUSY=0, no CORE_START; a following legal 4x4 CU_START clears ERR_FLAG and runs 1 sub-block.
REQ-036 SHALL be verified by a timeout test: TIMEOUT_CYCLES=255 with the core never answering.
- Expect ERR after 255 WAIT cycles, ERR_FLAG=1, no CU_DONE, IDLE next cycle.
- A second run with CORE_DONE on exactly the 255th cycle completes normally.
REQ-037 SHALL be verified by a wrap test: CU_COORD_X=252, 8x4 CU: expect sub-block X values 252, then 0.
REQ-038 SHALL be verified by a reset test: assert RESET_ALL mid-WAIT of sub-block 2 of a 16x16 CU.
- Expect all outputs 0 without waiting for a clock edge.
- A new CU_START after release starts from SUBBLOCK_IDX 0.
REQ-039 SHALL be verified by ignored-input tests:
- CU_START pulsed during WAIT: expect no effect;
- CORE_DONE pulsed in IDLE: expect no effect;
- a 128x128 CU: expect 1024 CORE_START pulses and final SUBBLOCK_IDX=1023.
